// File: rtl/ob_arb_pkg.sv
// ob_arb_pkg: shared state, tick type and defaults for the order-book tick arbiter
package ob_arb_pkg;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CLR_CYCLES = 8;
    localparam int IDX_W = 3;
    typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;
    typedef struct packed {
        logic [63:0] price;
        logic [63:0] qty;
        logic        side;
    } tick_t;
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i, input int n);
        return (int'(i) + 1 == n) ? '0 : i + 1'b1;
    endfunction
endpackage

// File: rtl/ob_rr_arbiter.sv
// ob_rr_arbiter: round-robin pick searching upward from ptr, wrapping at NUM_CH-1
module ob_rr_arbiter import ob_arb_pkg::*; #(
    parameter int NUM_CH = DEF_NUM_CH
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  idx
);
    logic [NUM_CH-1:0] rot;
    int off;
    int sel;
    // rotate so the pointer channel sits at bit 0, then take the lowest set bit
    assign rot = NUM_CH'({req, req} >> ptr);
    always_comb begin
        off = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) off = rot[k] ? k : off;
        sel = int'(ptr) + off;
        idx = IDX_W'(sel >= NUM_CH ? sel - NUM_CH : sel);
        grant = |req ? NUM_CH'(1) << idx : '0;
    end
endmodule

// File: rtl/ob_tick_arbiter.sv
// ob_tick_arbiter: merges feed-decoder ticks into one order-book stream with book-clear sequencing
// Define OB_ARB_SNAP_PRIO_EN to give channel 0 (snapshot feed) strict priority over the round-robin.
module ob_tick_arbiter import ob_arb_pkg::*; #(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int CLR_CYCLES = DEF_CLR_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  book_clear,
    input  logic [NUM_CH-1:0]     ch_valid,
    output logic [NUM_CH-1:0]     ch_ready,
    input  logic [NUM_CH*64-1:0]  ch_price,
    input  logic [NUM_CH*64-1:0]  ch_qty,
    input  logic [NUM_CH-1:0]     ch_side,
    output logic                  ob_rst_n,
    output logic [63:0]           ob_tick_price,
    output logic [63:0]           ob_tick_qty,
    output logic                  ob_tick_side,
    output logic                  ob_valid_in,
    input  logic                  ob_valid_out,
    output logic [2:0]            grant_ch,
    output logic [31:0]           tick_cnt,
    output logic                  ack_err
);
    localparam int CW = $clog2(CLR_CYCLES + 1);
    state_t state, state_nxt;
    logic [CW-1:0] clr_cnt;
    logic [IDX_W-1:0] ptr, rr_idx, sel_idx;
    logic [NUM_CH-1:0] rr_req, rr_grant, sel_grant;
    logic xfer, ptr_mv, vin_q, err_set, clr_done;
    tick_t tick;

    ob_rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
        .req   (rr_req),
        .ptr   (ptr),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

`ifdef OB_ARB_SNAP_PRIO_EN
    assign rr_req    = ch_valid & ~NUM_CH'(1);
    assign sel_grant = ch_valid[0] ? NUM_CH'(1) : rr_grant;
    assign sel_idx   = ch_valid[0] ? '0 : rr_idx;
    assign ptr_mv    = xfer && sel_idx != '0;
`else
    assign rr_req    = ch_valid;
    assign sel_grant = rr_grant;
    assign sel_idx   = rr_idx;
    assign ptr_mv    = xfer;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= (state == CLEAR && !book_clear) ? clr_cnt + 1'b1 : '0;
        end
    end

    assign clr_done = clr_cnt == CW'(CLR_CYCLES - 1);

    always_comb begin
        state_nxt = book_clear ? CLEAR
                  : (state != CLEAR || clr_done) ? (enable ? RUN : IDLE)
                  : CLEAR;
    end

    always_comb begin
        ch_ready = (!rst && state == RUN && enable && !book_clear) ? sel_grant : '0;
        xfer = |(ch_valid & ch_ready);
        err_set = (vin_q && !ob_valid_out) || (ob_valid_out && !vin_q && ob_rst_n);
    end

    always_comb begin
        tick = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (sel_grant[i]) tick = '{price: ch_price[64*i +: 64], qty: ch_qty[64*i +: 64], side: ch_side[i]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr           <= '0;
            ob_rst_n      <= 1'b0;
            ob_valid_in   <= 1'b0;
            vin_q         <= 1'b0;
            ob_tick_price <= '0;
            ob_tick_qty   <= '0;
            ob_tick_side  <= 1'b0;
            grant_ch      <= '0;
            tick_cnt      <= '0;
            ack_err       <= 1'b0;
        end else begin
            ob_rst_n    <= state_nxt != CLEAR;
            ob_valid_in <= xfer;
            vin_q       <= ob_valid_in;
            ack_err     <= ack_err | err_set;
            if (xfer) begin
                ob_tick_price <= tick.price;
                ob_tick_qty   <= tick.qty;
                ob_tick_side  <= tick.side;
                grant_ch      <= sel_idx;
                tick_cnt      <= tick_cnt + 1'b1;
            end
            if (ptr_mv) ptr <= wrap_inc(sel_idx, NUM_CH);
        end
    end
endmodule

// File: doc/ob_tick_arbiter.md
OB_TICK_ARBITER -- requirements
Module: ob_tick_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of feed-decoder requesters (2..8).
REQ-002 SHALL have parameter CLR_CYCLES, default 8, cycles the book reset is held low during a clear.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  in  1  permits grants when high.
REQ-006 SHALL have port book_clear  in  1  single-cycle request to clear the book.
REQ-007 SHALL have port ch_valid  in  NUM_CH  per-channel tick valid.
REQ-008 SHALL have port ch_ready  out  NUM_CH  per-channel accept, at most one-hot.
REQ-009 SHALL have port ch_price  in  NUM_CH*64  packed tick prices, channel i at [64*i+:64].
REQ-010 SHALL have port ch_qty  in  NUM_CH*64  packed tick quantities.
REQ-011 SHALL have port ch_side  in  NUM_CH  tick side, 0=buy, 1=sell.
REQ-012 SHALL have port ob_rst_n  out  1  registered active-low reset to the order book.
REQ-013 SHALL have ports ob_tick_price/ob_tick_qty (out, 64 each), ob_tick_side (out, 1) and ob_valid_in (out, 1), the registered tick to the book.
REQ-014 SHALL have port ob_valid_out  in  1  book's update acknowledge.
REQ-015 SHALL have port grant_ch  out  3  channel index of the tick currently on ob_valid_in.
REQ-016 SHALL have port tick_cnt  out  32  count of issued ticks, wrapping.
REQ-017 SHALL have port ack_err  out  1  sticky acknowledge-protocol error.

Function
REQ-018 SHALL implement FSM states IDLE, CLEAR, RUN.
REQ-019 CLEAR SHALL hold ob_rst_n=0 for exactly CLR_CYCLES cycles, then go to RUN if enable=1, else to IDLE.
REQ-020 IDLE SHALL go to CLEAR on book_clear, else to RUN on enable; book_clear SHALL have priority.
REQ-021 RUN SHALL go to CLEAR on book_clear, else to IDLE on enable=0.
REQ-022 book_clear asserted in CLEAR SHALL restart the CLR_CYCLES count.
REQ-023 ch_ready SHALL be combinational and non-zero only in RUN with enable=1 and book_clear=0.
REQ-024 ch_ready SHALL be asserted only for the channel selected by the arbiter among asserted ch_valid bits.
REQ-025 A transfer SHALL occur when ch_valid[i] and ch_ready[i] are both high; sources hold data while valid and not ready.
REQ-026 A transfer SHALL appear on ob_* and grant_ch the next cycle (latency 1), with ob_valid_in high for one cycle per transfer.
REQ-027 Throughput SHALL be one tick per cycle with no bubbles while any channel is valid.
REQ-028 Round-robin SHALL search from the pointer upward, wrapping at NUM_CH-1 to 0.
REQ-029 On a transfer the pointer SHALL move to granted+1 mod NUM_CH; with no transfer it SHALL hold.
REQ-030 ob_tick_* SHALL hold their last values when ob_valid_in=0.
REQ-031 tick_cnt SHALL increment per transfer and wrap 0xFFFFFFFF to 0.
REQ-032 ack_err SHALL set if ob_valid_in=1 at cycle t and ob_valid_out=0 at t+1.
REQ-033 ack_err SHALL also set if ob_valid_out=1 with ob_valid_in=0 in the prior cycle, while ob_rst_n=1.
REQ-034 ack_err SHALL clear only on rst.

Reset
REQ-035 rst SHALL force state CLEAR with counter 0, pointer 0, ob_rst_n=0, ob_valid_in=0, ob_tick_*=0, grant_ch=0, tick_cnt=0 and ack_err=0.
REQ-036 rst SHALL leave ch_ready=0.
REQ-037 rst asserted mid-transfer SHALL discard the pending registered tick.

Configuration
REQ-038 With OB_ARB_SNAP_PRIO_EN defined, channel 0 (snapshot feed) SHALL win strict priority whenever valid.
REQ-039 With OB_ARB_SNAP_PRIO_EN defined, channels 1..NUM_CH-1 SHALL round-robin, and the pointer SHALL not move on channel-0 grants.
REQ-040 Without OB_ARB_SNAP_PRIO_EN, all channels SHALL round-robin equally.

Structure
REQ-041 Package ob_arb_pkg SHALL hold the state enum, NUM_CH/CLR_CYCLES defaults, and the tick struct (price 64, qty 64, side 1).
REQ-042 Grant logic SHALL be a sub-module ob_rr_arbiter (request vector and pointer in; one-hot grant and index out).

Verification
REQ-043 Release rst, enable=1 -> ob_rst_n low 8 cycles, then RUN with ch_ready=0 until ch_valid is asserted.
REQ-044 All 4 channels valid continuously (macro off) -> grant_ch 0,1,2,3,0,..., tick_cnt=8 after 8 cycles.
REQ-045 Ch2 price 0x64 side 0 alone -> ob_tick_price=0x64 and ob_valid_in one cycle later; book echo gives ack_err=0.
REQ-046 book_clear during continuous traffic -> no transfer that cycle, ob_rst_n low 8 cycles, traffic resumes with the pointer preserved.
REQ-047 Macro on, ch0 and ch1 valid 3 cycles -> grants 0,0,0; with ob_valid_out forced 0 -> ack_err=1 and sticky.
